lif_array: RTL and testbench

Parametrised array of N leaky integrate-and-fire neurons sharing one clock, with runtime-configurable threshold, reset mode, refractory period and nearest-neighbour spike coupling. Each neuron integrates its own input current and leaks by a configurable shift. It emits registered one-cycle spike pulses. The array replaces single fixed-threshold neurons at the top level. One neuron's membrane state is observable through a select mux.

---
 rtl/lif_pkg.sv | 18 +
 rtl/lif_if.sv | 34 +++
 rtl/lif_cell.sv | 73 +++++++
 rtl/lif_array.sv | 79 +++++++
 tb/tb_lif_array.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lif_pkg.sv
// Shared types and constants for the leaky integrate-and-fire neuron array.
package lif_pkg;

    typedef enum logic {
        LIF_MODE_RESET = 1'b0,
        LIF_MODE_SUB   = 1'b1
    } lif_mode_e;

    // leaked + input + coupling can exceed WIDTH bits by at most two bits
    localparam int LIF_SAT_EXTRA = 2;

    localparam int LIF_N_NEURONS_DEF  = 4;
    localparam int LIF_WIDTH_DEF      = 8;
    localparam int LIF_LEAK_SHIFT_DEF = 1;
    localparam int LIF_REFRAC_W_DEF   = 4;
    localparam int LIF_THRESH_RST_DEF = 200;

endpackage

// File: rtl/lif_if.sv
// Bus bundle between the neuron array and its driver: stimulus, config and observation.
interface lif_if
    import lif_pkg::*;
#(
    parameter int N_NEURONS = LIF_N_NEURONS_DEF,
    parameter int WIDTH     = LIF_WIDTH_DEF,
    parameter int REFRAC_W  = LIF_REFRAC_W_DEF
);
    localparam int SEL_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

    // No backpressure: en qualifies a neuron update and cfg_we a config load at
    // each clock edge; the array always accepts, so there is no ready signal.
    logic                          en;
    logic [N_NEURONS*WIDTH-1:0]    current;
    logic                          cfg_we;
    logic [WIDTH-1:0]              cfg_thresh;
    logic                          cfg_mode;
    logic [REFRAC_W-1:0]           cfg_refrac;
    logic [WIDTH-1:0]              cfg_weight;
    logic [SEL_W-1:0]              state_sel;
    logic [N_NEURONS-1:0]          spike;
    logic [WIDTH-1:0]              state_out;

    modport master (
        output en, current, cfg_we, cfg_thresh, cfg_mode, cfg_refrac, cfg_weight, state_sel,
        input  spike, state_out
    );

    modport slave (
        input  en, current, cfg_we, cfg_thresh, cfg_mode, cfg_refrac, cfg_weight, state_sel,
        output spike, state_out
    );

endinterface

// File: rtl/lif_cell.sv
// One leaky integrate-and-fire neuron: membrane state, refractory counter and spike flag.
module lif_cell
    import lif_pkg::*;
#(
    parameter int WIDTH      = LIF_WIDTH_DEF,
    parameter int LEAK_SHIFT = LIF_LEAK_SHIFT_DEF,
    parameter int REFRAC_W   = LIF_REFRAC_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_en,
    input  logic [WIDTH-1:0]    i_current,
    input  logic [WIDTH-1:0]    i_thresh,
    input  lif_mode_e           i_mode,
    input  logic [REFRAC_W-1:0] i_refrac,
    input  logic [WIDTH-1:0]    i_weight,
    input  logic                i_couple,
    output logic                o_spike,
    output logic [WIDTH-1:0]    o_state
);
    localparam int SUM_W = WIDTH + LIF_SAT_EXTRA;
    localparam logic [SUM_W-1:0] SAT_MAX = {{LIF_SAT_EXTRA{1'b0}}, {WIDTH{1'b1}}};

    logic [WIDTH-1:0]    r_state;
    logic [REFRAC_W-1:0] r_refrac;
    logic                r_spike;

    logic [WIDTH-1:0]    w_leaked;
    logic [WIDTH-1:0]    w_inp;
    logic [WIDTH-1:0]    w_couple;
    logic [SUM_W-1:0]    w_sum_wide;
    logic [WIDTH-1:0]    w_sum;
    logic                w_fire;
    logic [WIDTH-1:0]    w_next_state;
    logic [REFRAC_W-1:0] w_next_refrac;

    assign w_leaked   = r_state - (r_state >> LEAK_SHIFT);
    assign w_inp      = (r_refrac != '0) ? '0 : i_current;
    assign w_couple   = i_couple ? i_weight : '0;
    assign w_sum_wide = SUM_W'(w_leaked) + SUM_W'(w_inp) + SUM_W'(w_couple);
    assign w_sum      = (w_sum_wide > SAT_MAX) ? '1 : w_sum_wide[WIDTH-1:0];
    assign w_fire     = (r_refrac == '0) && (w_sum >= i_thresh);

    always_comb begin
        w_next_state  = w_sum;
        w_next_refrac = r_refrac;
        if (w_fire) begin
            w_next_refrac = i_refrac;
            w_next_state  = (i_mode == LIF_MODE_SUB) ? (w_sum - i_thresh) : '0;
        end else if (r_refrac != '0) begin
            w_next_refrac = r_refrac - 1'b1;
        end
    end

    // Spike clears on a held cycle so every pulse lasts exactly one clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= '0;
            r_refrac <= '0;
            r_spike  <= 1'b0;
        end else if (i_en) begin
            r_state  <= w_next_state;
            r_refrac <= w_next_refrac;
            r_spike  <= w_fire;
        end else begin
            r_spike  <= 1'b0;
        end
    end

    assign o_spike = r_spike;
    assign o_state = r_state;

endmodule

// File: rtl/lif_array.sv
// Array of LIF neurons with shared runtime config, nearest-neighbour coupling and a state mux.
module lif_array
    import lif_pkg::*;
#(
    parameter int N_NEURONS  = LIF_N_NEURONS_DEF,
    parameter int WIDTH      = LIF_WIDTH_DEF,
    parameter int LEAK_SHIFT = LIF_LEAK_SHIFT_DEF,
    parameter int REFRAC_W   = LIF_REFRAC_W_DEF,
    parameter int THRESH_RST = LIF_THRESH_RST_DEF
) (
    input  logic clk,
    input  logic rst_n,
    lif_if.slave bus
);
    logic [WIDTH-1:0]    r_thresh;
    lif_mode_e           r_mode;
    logic [REFRAC_W-1:0] r_refrac;
    logic [WIDTH-1:0]    r_weight;

    logic [N_NEURONS-1:0] w_spike;
    logic [N_NEURONS-1:0] w_couple;
    logic [WIDTH-1:0]     w_state [N_NEURONS];
    logic [WIDTH-1:0]     w_state_out;

    // Cells sample the registered config, so a same-edge write only affects later edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_thresh <= WIDTH'(THRESH_RST);
            r_mode   <= LIF_MODE_RESET;
            r_refrac <= '0;
            r_weight <= '0;
        end else if (bus.cfg_we) begin
            r_thresh <= bus.cfg_thresh;
            r_mode   <= lif_mode_e'(bus.cfg_mode);
            r_refrac <= bus.cfg_refrac;
            r_weight <= bus.cfg_weight;
        end
    end

    for (genvar g = 0; g < N_NEURONS; g++) begin : g_cell
        if (g == 0) begin : g_head
            assign w_couple[g] = 1'b0;
        end else begin : g_chain
            assign w_couple[g] = w_spike[g-1];
        end

        lif_cell #(
            .WIDTH      (WIDTH),
            .LEAK_SHIFT (LEAK_SHIFT),
            .REFRAC_W   (REFRAC_W)
        ) u_cell (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_en      (bus.en),
            .i_current (bus.current[g*WIDTH +: WIDTH]),
            .i_thresh  (r_thresh),
            .i_mode    (r_mode),
            .i_refrac  (r_refrac),
            .i_weight  (r_weight),
            .i_couple  (w_couple[g]),
            .o_spike   (w_spike[g]),
            .o_state   (w_state[g])
        );
    end

    // Out-of-range selects fall through to zero.
    always_comb begin
        w_state_out = '0;
        for (int k = 0; k < N_NEURONS; k++) begin
            if (int'(bus.state_sel) == k) begin
                w_state_out = w_state[k];
            end
        end
    end

    assign bus.spike     = w_spike;
    assign bus.state_out = w_state_out;

endmodule

// File: tb/tb_lif_array.sv
// Directed and randomized checks of lif_array against an integer reference model.
module tb_lif_array;
    import lif_pkg::*;

    localparam int N     = 3;
    localparam int W     = 8;
    localparam int LS    = 1;
    localparam int RW    = 4;
    localparam int TR    = 200;
    localparam int NSEL  = 4;
    localparam int MAXV  = (1 << W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    lif_if #(.N_NEURONS(N), .WIDTH(W), .REFRAC_W(RW)) bus ();

    lif_array #(
        .N_NEURONS  (N),
        .WIDTH      (W),
        .LEAK_SHIFT (LS),
        .REFRAC_W   (RW),
        .THRESH_RST (TR)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    int m_state [N];
    int m_ref   [N];
    int m_spk   [N];
    int m_cur   [N];
    int m_thresh, m_mode, m_refrac, m_weight;
    int p_thresh, p_mode, p_refrac, p_weight;
    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];
    logic [W-1:0] v;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        logic [31:0] e;
        exp_q.push_back(exp_v);
        e = exp_q.pop_front();
        n_checks++;
        assert (obs === e) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_state[i] = 0;
            m_ref[i]   = 0;
            m_spk[i]   = 0;
        end
        m_thresh = TR;
        m_mode   = 0;
        m_refrac = 0;
        m_weight = 0;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) bus.current[i*W +: W] = W'(m_cur[i]);
        bus.cfg_thresh = W'(p_thresh);
        bus.cfg_mode   = p_mode[0];
        bus.cfg_refrac = RW'(p_refrac);
        bus.cfg_weight = W'(p_weight);
    endtask

    task automatic model_edge(input bit en_v, input bit we_v);
        int old_spk [N];
        int leaked, inp, cpl, sum;
        if (en_v) begin
            old_spk = m_spk;
            for (int i = 0; i < N; i++) begin
                leaked = m_state[i] - (m_state[i] >> LS);
                inp    = (m_ref[i] > 0) ? 0 : m_cur[i];
                cpl    = (i > 0 && old_spk[i-1] != 0) ? m_weight : 0;
                sum    = leaked + inp + cpl;
                if (sum > MAXV) sum = MAXV;
                if (m_ref[i] == 0 && sum >= m_thresh) begin
                    m_spk[i]   = 1;
                    m_ref[i]   = m_refrac;
                    m_state[i] = (m_mode != 0) ? sum - m_thresh : 0;
                end else begin
                    m_spk[i]   = 0;
                    m_state[i] = sum;
                    if (m_ref[i] > 0) m_ref[i]--;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) m_spk[i] = 0;
        end
        if (we_v) begin
            m_thresh = p_thresh;
            m_mode   = p_mode;
            m_refrac = p_refrac;
            m_weight = p_weight;
        end
    endtask

    task automatic get_state(input int k, output logic [W-1:0] val);
        bus.state_sel = 2'(k);
        #1;
        val = bus.state_out;
    endtask

    task automatic check_all(input string tag);
        logic [31:0] e;
        logic [W-1:0] s;
        e = '0;
        for (int i = 0; i < N; i++) e[i] = m_spk[i][0];
        check({tag, "_spike"}, 32'(bus.spike), e);
        for (int k = 0; k < NSEL; k++) begin
            get_state(k, s);
            check($sformatf("%s_state%0d", tag, k), 32'(s), (k < N) ? 32'(m_state[k]) : 32'd0);
        end
    endtask

    task automatic step(input bit en_v, input bit we_v, input string tag);
        drive_inputs();
        bus.en     = en_v;
        bus.cfg_we = we_v;
        @(posedge clk);
        model_edge(en_v, we_v);
        #1;
        bus.cfg_we = 1'b0;
        check_all(tag);
    endtask

    task automatic arst(input string tag);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_cfg(input int th, input int md, input int rf, input int wt);
        p_thresh = th;
        p_mode   = md;
        p_refrac = rf;
        p_weight = wt;
    endtask

    task automatic set_cur(input int c0, input int c1, input int c2);
        m_cur[0] = c0;
        m_cur[1] = c1;
        m_cur[2] = c2;
    endtask

    initial begin
        bus.en        = 1'b0;
        bus.cfg_we    = 1'b0;
        bus.state_sel = '0;
        set_cfg(TR, 0, 0, 0);
        set_cur(0, 0, 0);
        drive_inputs();
        model_reset();
        #3;
        check_all("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Mode 0, refractory 2: period of 4 on neuron 0
        set_cfg(200, 0, 2, 0);
        step(1'b0, 1'b1, "t1_cfg");
        set_cur(150, 0, 0);
        step(1'b1, 1'b0, "t1_e1");
        get_state(0, v); check("t1_e1_s0", 32'(v), 32'd150);
        step(1'b1, 1'b0, "t1_e2");
        check("t1_e2_spk0", 32'(bus.spike[0]), 32'd1);
        get_state(0, v); check("t1_e2_s0", 32'(v), 32'd0);
        step(1'b1, 1'b0, "t1_e3");
        step(1'b1, 1'b0, "t1_e4");
        get_state(0, v); check("t1_e4_s0", 32'(v), 32'd0);
        step(1'b1, 1'b0, "t1_e5");
        get_state(0, v); check("t1_e5_s0", 32'(v), 32'd150);
        step(1'b1, 1'b0, "t1_e6");
        check("t1_e6_spk0", 32'(bus.spike[0]), 32'd1);

        // Mode 1 subtract-threshold
        arst("t2_rst");
        set_cfg(200, 1, 0, 0);
        step(1'b0, 1'b1, "t2_cfg");
        step(1'b1, 1'b0, "t2_e1");
        step(1'b1, 1'b0, "t2_e2");
        get_state(0, v); check("t2_e2_s0", 32'(v), 32'd25);
        step(1'b1, 1'b0, "t2_e3");
        get_state(0, v); check("t2_e3_s0", 32'(v), 32'd163);
        check("t2_e3_spk0", 32'(bus.spike[0]), 32'd0);

        // Saturation at the top of the range
        arst("t3_rst");
        set_cfg(255, 1, 0, 0);
        step(1'b0, 1'b1, "t3_cfg");
        set_cur(200, 0, 0);
        step(1'b1, 1'b0, "t3_e1");
        set_cur(255, 0, 0);
        step(1'b1, 1'b0, "t3_e2");
        check("t3_e2_spk0", 32'(bus.spike[0]), 32'd1);
        get_state(0, v); check("t3_e2_s0", 32'(v), 32'd0);
        step(1'b1, 1'b0, "t3_e3");

        // Nearest-neighbour coupling, no wrap from the last neuron to neuron 0
        arst("t4_rst");
        set_cfg(200, 0, 0, 200);
        step(1'b0, 1'b1, "t4_cfg");
        set_cur(200, 0, 0);
        step(1'b1, 1'b0, "t4_e1");
        check("t4_e1_spk", 32'(bus.spike), 32'b001);
        step(1'b1, 1'b0, "t4_e2");
        check("t4_e2_spk", 32'(bus.spike), 32'b011);
        step(1'b1, 1'b0, "t4_e3");
        check("t4_e3_spk", 32'(bus.spike), 32'b111);
        set_cur(0, 0, 0);
        step(1'b1, 1'b0, "t4_e4");
        check("t4_e4_spk", 32'(bus.spike), 32'b110);

        // Config write coinciding with a would-be spike uses the old threshold
        arst("t5_rst");
        set_cfg(100, 0, 0, 0);
        set_cur(150, 0, 0);
        step(1'b1, 1'b1, "t5_e1");
        check("t5_e1_spk0", 32'(bus.spike[0]), 32'd0);
        step(1'b1, 1'b0, "t5_e2");
        check("t5_e2_spk0", 32'(bus.spike[0]), 32'd1);

        // Asynchronous reset during refractory with en toggling
        arst("t6_rst");
        set_cfg(100, 1, 5, 0);
        step(1'b0, 1'b1, "t6_cfg");
        step(1'b1, 1'b0, "t6_e1");
        step(1'b0, 1'b0, "t6_hold");
        step(1'b1, 1'b0, "t6_e2");
        step(1'b0, 1'b0, "t6_hold2");
        arst("t6_mid");
        step(1'b1, 1'b0, "t6_fresh1");
        get_state(0, v); check("t6_fresh1_s0", 32'(v), 32'd150);
        step(1'b1, 1'b0, "t6_fresh2");
        check("t6_fresh2_spk0", 32'(bus.spike[0]), 32'd1);
        arst("t6_spkclr");

        // Randomized traffic against the model
        for (int it = 0; it < 400; it++) begin
            bit en_v, we_v;
            for (int i = 0; i < N; i++)
                m_cur[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom_range(0, MAXV);
            en_v = ($urandom_range(0, 7) != 0);
            we_v = ($urandom_range(0, 15) == 0);
            if (we_v) begin
                set_cfg(($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, MAXV),
                        $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, MAXV));
            end
            if ($urandom_range(0, 99) == 0) begin
                arst($sformatf("rnd%0d_rst", it));
            end else begin
                step(en_v, we_v, $sformatf("rnd%0d", it));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
